// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned HDR_BYTES  = 2;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_W      = 16;

endpackage

// File: rtl/word_assembler.sv
// Collects bytes little-endian into a 32-bit word; o_word already includes
// the byte being strobed so the completing cycle can capture it directly.
module word_assembler
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_byte_vld,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  localparam int unsigned CNT_W = $clog2(WORD_BYTES);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_word;

  always_comb begin
    o_word = r_word;
    if (i_byte_vld) begin
      o_word[{r_cnt, 3'b000} +: 8] = i_byte;
    end
    o_word_full = i_byte_vld && (r_cnt == CNT_W'(WORD_BYTES - 1));
  end

  // Counter wraps to 0 on the completing byte, ready for the next word.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_byte_vld) begin
      r_cnt  <= r_cnt + 1'b1;
      r_word <= o_word;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: length-prefixed byte stream into instruction memory, holding
// the core in reset until the image is complete.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_data,
  output logic              o_imem_wr,
  output logic              o_core_hold,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_words_loaded
);

  localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(1) << ADDR_W;

  loader_state_t     r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [ADDR_W:0]   r_idx, w_idx_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [31:0]       r_data, w_data_nxt;
  logic              r_wr, w_wr_nxt;
  logic              r_hold, w_hold_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;

  logic              w_accept, w_clear, w_byte_vld, w_full;
  logic [31:0]       w_word;
  logic [LEN_W-1:0]  w_len_full;
  logic [LEN_W:0]    w_idx_inc;

  assign o_rx_ready = (r_state == LEN_LO) || (r_state == LEN_HI) || (r_state == DATA);
  assign w_accept   = i_rx_valid && o_rx_ready;
  assign w_byte_vld = w_accept && (r_state == DATA);
  assign w_len_full = {i_rx_data, r_len[7:0]};
  // Index is widened so the N == capacity case compares without wrapping.
  assign w_idx_inc  = (LEN_W + 1)'(r_idx) + (LEN_W + 1)'(1);

  word_assembler u_asm (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (w_clear),
    .i_byte_vld  (w_byte_vld),
    .i_byte      (i_rx_data),
    .o_word      (w_word),
    .o_word_full (w_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_wr_nxt    = 1'b0;
    w_hold_nxt  = r_hold;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_clear     = 1'b0;
    unique case (r_state)
      LEN_LO: begin
        if (w_accept) begin
          w_len_nxt[7:0] = i_rx_data;
          w_state_nxt    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (w_accept) begin
          w_len_nxt = w_len_full;
          if (w_len_full == '0) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            w_hold_nxt  = 1'b0;
          end else if ({1'b0, w_len_full} > CAPACITY) begin
            w_state_nxt = ERR;
            w_err_nxt   = 1'b1;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_full) begin
          w_wr_nxt    = 1'b1;
          w_addr_nxt  = r_idx[ADDR_W-1:0];
          w_data_nxt  = w_word;
          w_state_nxt = WRITE;
        end
      end
      WRITE: begin
        w_idx_nxt = w_idx_inc[ADDR_W:0];
        if (w_idx_inc == {1'b0, r_len}) begin
          w_state_nxt = DONE;
          w_done_nxt  = 1'b1;
          w_hold_nxt  = 1'b0;
        end else begin
          w_state_nxt = DATA;
        end
      end
      DONE, ERR: begin
        if (i_start) begin
          w_state_nxt = LEN_LO;
          w_idx_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_err_nxt   = 1'b0;
          w_hold_nxt  = 1'b1;
          w_clear     = 1'b1;
        end
      end
      default: w_state_nxt = LEN_LO;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= LEN_LO;
      r_len   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wr    <= 1'b0;
      r_hold  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_wr    <= w_wr_nxt;
      r_hold  <= w_hold_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_imem_addr    = r_addr;
  assign o_imem_data    = r_data;
  assign o_imem_wr      = r_wr;
  assign o_core_hold    = r_hold;
  assign o_done         = r_done;
  assign o_error        = r_err;
  assign o_words_loaded = r_idx;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a 16-word memory (ADDR_W = 4).
module tb_prog_loader;

  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          imem_wr;
  logic          core_hold;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  int n_checks = 0;
  int n_errs   = 0;
  int n_wr     = 0;
  int n_wide   = 0;
  int wr_base;
  bit use_gaps = 1'b0;
  logic prev_wr;
  logic [31:0] mem [16];

  prog_loader #(.ADDR_W(AW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_rx_ready     (rx_ready),
    .o_imem_addr    (imem_addr),
    .o_imem_data    (imem_data),
    .o_imem_wr      (imem_wr),
    .o_core_hold    (core_hold),
    .o_done         (done),
    .o_error        (error),
    .o_words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Memory image and write-strobe width monitor.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_wr <= 1'b0;
    end else begin
      prev_wr <= imem_wr;
      if (imem_wr) begin
        mem[imem_addr] <= imem_data;
        n_wr <= n_wr + 1;
        if (prev_wr) n_wide <= n_wide + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called and returns just after a falling edge.
  task automatic send_byte(input logic [7:0] b);
    int  t;
    bit  acc;
    if (use_gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t   = 0;
    acc = 1'b0;
    while (!acc) begin
      acc = rx_ready;
      @(negedge clk);
      t++;
      if (!acc && t > 20) begin
        check("accept_timeout", 32'(rx_ready), 32'd1);
        rx_valid = 1'b0;
        return;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] fill_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, b + 8'h30, 8'hC3 ^ b};
  endfunction

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_hold"}, 32'(core_hold), 32'd1);
    check({pfx, "_ready"}, 32'(rx_ready), 32'd1);
    check({pfx, "_wr"}, 32'(imem_wr), 32'd0);
    check({pfx, "_addr"}, 32'(imem_addr), 32'd0);
    check({pfx, "_data"}, imem_data, 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_err"}, 32'(error), 32'd0);
    check({pfx, "_wl"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Two-word boot image.
    send_hdr(16'd2);
    send_word(32'h00A00513);
    send_word(32'h0000006F);
    check("t1_wr", 32'(imem_wr), 32'd1);
    check("t1_addr", 32'(imem_addr), 32'd1);
    check("t1_data", imem_data, 32'h0000006F);
    check("t1_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_hold", 32'(core_hold), 32'd0);
    check("t1_wl", 32'(words_loaded), 32'd2);
    check("t1_wr_low", 32'(imem_wr), 32'd0);
    check("t1_addr_held", 32'(imem_addr), 32'd1);
    check("t1_ready", 32'(rx_ready), 32'd0);
    check("t1_mem0", mem[0], 32'h00A00513);
    check("t1_mem1", mem[1], 32'h0000006F);
    check("t1_nwr", 32'(n_wr), 32'd2);

    // Reload one word; a start pulse mid-word must be ignored.
    pulse_start();
    check("rearm_done", 32'(done), 32'd0);
    check("rearm_hold", 32'(core_hold), 32'd1);
    check("rearm_wl", 32'(words_loaded), 32'd0);
    check("rearm_ready", 32'(rx_ready), 32'd1);
    send_hdr(16'd1);
    send_byte(8'hEF);
    send_byte(8'hBE);
    pulse_start();
    send_byte(8'hAD);
    send_byte(8'hDE);
    @(negedge clk);
    check("rl_mem0", mem[0], 32'hDEADBEEF);
    check("rl_mem1_kept", mem[1], 32'h0000006F);
    check("rl_wl", 32'(words_loaded), 32'd1);
    check("rl_done", 32'(done), 32'd1);

    // Empty image.
    pulse_start();
    wr_base = n_wr;
    send_hdr(16'd0);
    check("n0_done", 32'(done), 32'd1);
    check("n0_hold", 32'(core_hold), 32'd0);
    check("n0_wl", 32'(words_loaded), 32'd0);
    repeat (3) @(negedge clk);
    check("n0_nowr", 32'(n_wr - wr_base), 32'd0);

    // Oversized header.
    pulse_start();
    send_hdr(16'h0011);
    check("err_flag", 32'(error), 32'd1);
    check("err_hold", 32'(core_hold), 32'd1);
    check("err_ready", 32'(rx_ready), 32'd0);
    check("err_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    check("err_nowr", 32'(n_wr - wr_base), 32'd0);
    pulse_start();
    check("err_clear", 32'(error), 32'd0);
    check("err_rearm_ready", 32'(rx_ready), 32'd1);
    check("err_rearm_hold", 32'(core_hold), 32'd1);

    // Three words with random valid gaps.
    use_gaps = 1'b1;
    send_hdr(16'd3);
    send_word(32'h11223344);
    send_word(32'h55667788);
    send_word(32'h99AABBCC);
    use_gaps = 1'b0;
    @(negedge clk);
    check("gap_mem0", mem[0], 32'h11223344);
    check("gap_mem1", mem[1], 32'h55667788);
    check("gap_mem2", mem[2], 32'h99AABBCC);
    check("gap_wl", 32'(words_loaded), 32'd3);
    check("gap_nwr", 32'(n_wr - wr_base), 32'd3);
    check("gap_done", 32'(done), 32'd1);

    // Exact fill: N equals capacity.
    pulse_start();
    wr_base = n_wr;
    send_hdr(16'd16);
    for (int i = 0; i < 16; i++) send_word(fill_word(i));
    check("fill_last_addr", 32'(imem_addr), 32'd15);
    check("fill_last_wr", 32'(imem_wr), 32'd1);
    @(negedge clk);
    check("fill_done", 32'(done), 32'd1);
    check("fill_err", 32'(error), 32'd0);
    check("fill_wl", 32'(words_loaded), 32'd16);
    check("fill_nwr", 32'(n_wr - wr_base), 32'd16);
    check("fill_mem0", mem[0], fill_word(0));
    check("fill_mem7", mem[7], fill_word(7));
    check("fill_mem15", mem[15], fill_word(15));

    // Reset in the middle of the second word.
    pulse_start();
    send_hdr(16'd2);
    send_word(32'h01020304);
    send_byte(8'h05);
    send_byte(8'h06);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_hdr(16'd1);
    send_word(32'hCAFEF00D);
    @(negedge clk);
    check("post_mem0", mem[0], 32'hCAFEF00D);
    check("post_mem1_kept", mem[1], fill_word(1));
    check("post_wl", 32'(words_loaded), 32'd1);
    check("post_done", 32'(done), 32'd1);
    check("post_hold", 32'(core_hold), 32'd0);

    check("strobe_width", 32'(n_wide), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader sitting directly upstream of the instruction memory of the single-cycle core. It accepts a byte stream from the serial receiver, assembles little-endian 32-bit words, and writes them sequentially into instruction memory from word 0. While loading, it holds the core in reset, then releases it. It re-arms on a `start` pulse for reloads without a board reset.

## Interface
- `ADDR_W`, 10, instruction-memory word-address width; capacity is 2^ADDR_W words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle re-arm pulse; only honoured in DONE or ERR.
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle; a transfer occurs when `rx_valid && rx_ready`.
- `imem_addr`  out  ADDR_W  word address for the write (same as the core's `pc[31:2]` indexing).
- `imem_data`  out  32  word to write.
- `imem_wr`  out  1  one-cycle write strobe.
- `core_hold`  out  1  high = core held in reset.
- `done`  out  1  load finished successfully.
- `error`  out  1  header length exceeded capacity.
- `words_loaded`  out  ADDR_W+1  count of words written this load.

## Operation
- Frame format: 2-byte little-endian word count N, then N words of 4 bytes each, least-significant byte first. Byte k of a word lands in bits [8k+7:8k].
- FSM states and transitions:
  - LEN_LO: on transfer, latch N[7:0], go to LEN_HI.
  - LEN_HI: on transfer, latch N[15:8]. Then:
    - N == 0: go to DONE.
    - N > 2^ADDR_W: go to ERR.
    - Otherwise: go to DATA.
  - DATA: accept bytes; byte counter 0..3. On the 4th transfer, go to WRITE.
  - WRITE: `imem_wr`=1 with `imem_addr` = word index and `imem_data` = assembled word. Then increment the word index and `words_loaded`. If the new index == N, go to DONE; else go to DATA.
  - DONE: `core_hold`=0, `done`=1. A `start` pulse moves to LEN_LO.
  - ERR: `core_hold`=1, `error`=1. A `start` pulse moves to LEN_LO.
- `rx_ready` is a combinational decode of state: high in LEN_LO, LEN_HI, and DATA; low in WRITE, DONE, and ERR.
- `start` is ignored in LEN_LO, LEN_HI, DATA, and WRITE.
- On re-arm:
  - Cleared: word index, byte counter, `words_loaded`, `done`, `error`.
  - Set: `core_hold`=1.
  - Memory contents are not cleared.
- `rx_valid` low stalls any state without side effects. Partial words are held indefinitely; there is no timeout.

## Timing
- Reset values:
  - State = LEN_LO (boot load begins immediately).
  - `core_hold`=1, `rx_ready`=1, `imem_wr`=0, `imem_addr`=0, `imem_data`=0.
  - `done`=0, `error`=0, `words_loaded`=0.
  - Byte counter and word index = 0.
- All outputs except `rx_ready` are registered.
- `imem_wr` is high for exactly one cycle per word: the cycle after the edge on which the 4th byte was accepted.
- `imem_addr` and `imem_data` hold their last values while `imem_wr`=0.
- With back-to-back `rx_valid`, throughput is one word per 5 cycles (4 accepts + 1 WRITE).
- `done` and `core_hold` change on the edge leaving WRITE (or LEN_HI when N=0). They are visible in the cycle after the final `imem_wr` cycle.
- `words_loaded` updates on the same edge that ends the WRITE cycle.
- Reset asserted mid-operation: asynchronously returns all state and outputs to reset values. A partial word is discarded, and already-written words remain in memory.
- N == 2^ADDR_W is legal and fills memory exactly. The last write goes to address 2^ADDR_W−1, and the word index never wraps.

## Structure
- Shared package `loader_pkg`:
  - State enum `loader_state_t` {LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR}.
  - Constants `HDR_BYTES`=2, `WORD_BYTES`=4.
  - Length width `LEN_W`=16.
- One sub-module, `word_assembler`:
  - Byte counter and 32-bit shift/insert register.
  - Inputs: `clk`, `rst`, `clear`, byte strobe, byte.
  - Outputs: assembled word and a `word_full` flag.
- The FSM, address counter, and output registers live in `prog_loader`.

## Test plan
- Reset, then stream 02 00, 13 05 A0 00, 6F 00 00 00 → writes addr 0 = 0x00A00513 and addr 1 = 0x0000006F. `done`=1, `core_hold`=0, `words_loaded`=2.
- Header 00 00 → no `imem_wr` pulses. `done`=1 one cycle after the 2nd byte is accepted.
- ADDR_W=4, header 11 00 (N=17) → `error`=1, `core_hold`=1, `rx_ready`=0, no writes. A `start` pulse returns to LEN_LO with `error`=0.
- Random `rx_valid` gaps over 3 words → identical memory image. Each `imem_wr` is exactly 1 cycle wide, and no bytes are lost or duplicated.
- Assert `rst` low after the 2nd data byte of word 1 → all outputs at reset values, `core_hold`=1. A fresh 1-word frame then writes addr 0 correctly.
- After DONE, pulse `start` and load 1 word 0xDEADBEEF → addr 0 is overwritten, `words_loaded`=1. `start` pulsed during DATA has no effect.
